// File: rtl/event_encoder_4to2.sv
// Sequential 4-to-2 event encoder: sticky capture of four request lines,
// round-robin or fixed-priority selection, valid/ready delivery of the index.
module event_encoder_4to2 #(
    parameter bit RR_MODE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_0,
    input  logic       in_1,
    input  logic       in_2,
    input  logic       in_3,
    output logic [1:0] out_sel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] pending,
    output logic       dbg_state
);

    // Output handshake: out_sel is meaningful only while out_valid=1; a
    // transfer happens on a rising edge where out_valid=1 and out_ready=1.
    // out_sel and out_valid stay stable until that transfer.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t      r_state;
    logic [1:0]  r_ptr;
    logic [3:0]  r_pending;
    logic [1:0]  r_sel;
    logic        r_valid;

    logic [3:0]  w_in;
    logic [1:0]  w_start;
    logic [1:0]  w_cand;
    logic [1:0]  w_idx;
    logic        w_found;
    logic        w_advance;
    logic        w_grant;
    logic [3:0]  w_clear;

    assign w_in    = {in_3, in_2, in_1, in_0};
    assign w_start = RR_MODE ? r_ptr : 2'd0;

    // Scan pending from the start index, wrapping 3 -> 0; first set bit wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = 2'd0;
        w_cand  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_cand = w_start + 2'(i);
            if (!w_found && r_pending[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    assign w_advance = (r_state == ST_IDLE) || out_ready;
    assign w_grant   = w_advance && w_found;
    assign w_clear   = w_grant ? (4'b0001 << w_idx) : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 2'd0;
            r_pending <= 4'b0000;
            r_sel     <= 2'd0;
            r_valid   <= 1'b0;
        end else begin
            // A new event on the granting edge overrides the clear.
            r_pending <= (r_pending & ~w_clear) | w_in;
            if (w_grant && RR_MODE) begin
                r_ptr <= w_idx + 2'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_sel   <= w_idx;
                        r_valid <= 1'b1;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        if (w_grant) begin
                            r_sel   <= w_idx;
                            r_valid <= 1'b1;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_sel   = r_sel;
    assign out_valid = r_valid;
    assign pending   = r_pending;
    assign dbg_state = (r_state == ST_HOLD);

endmodule

// File: doc/event_encoder_4to2.md
Name: event_encoder_4to2

Overview:
- Sequential 4-to-2 encoder: the inverse of the 2-to-4 select decoder.
- Four single-bit event/request lines (in_0..in_3) are captured into sticky pending flags.
- Each pending event is encoded to a 2-bit index and delivered over a valid/ready output handshake, one index per transfer.
- Sits between one-hot/request sources (decoder outputs, buttons, unit-done strobes) and a consumer that needs a compact index, e.g. a controller FSM or mux select.

Parameters:
- RR_MODE, 1, arbitration mode. 1 = round-robin priority; 0 = fixed priority with in_0 highest, in_3 lowest.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_0  input  1  event/request line 0, sampled every rising edge.
- in_1  input  1  event/request line 1.
- in_2  input  1  event/request line 2.
- in_3  input  1  event/request line 3.
- out_sel  output  2  encoded index of the granted event.
- out_valid  output  1  out_sel holds a valid index.
- out_ready  input  1  consumer accepts out_sel this cycle.
- pending  output  4  registered sticky flags; bit k = event k captured, not yet issued.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately regardless of clk):
  - pending=4'b0000, out_sel=2'b00, out_valid=0.
  - Round-robin pointer=0; state=IDLE.
  - All captured events are discarded; a reset mid-handshake drops the offered index.
- Capture:
  - At each edge, pending[k] is set if in_k=1.
  - A level held high re-sets the bit every cycle, so a held line produces repeated grants.
- Selection:
  - Uses the registered pending value only, never the current inputs.
  - RR_MODE=1: search starts at pointer and wraps 3->0. After granting index k, pointer <= (k+1) mod 4, so 3 wraps to 0.
  - RR_MODE=0: lowest set index wins; the pointer is unused.
- FSM states: IDLE and HOLD.
- IDLE:
  - out_valid=0.
  - If pending!=0 at an edge: out_sel <= selected index, out_valid <= 1, clear that pending bit, state -> HOLD.
  - Otherwise remain in IDLE.
- HOLD:
  - out_valid=1; out_sel and out_valid hold stable while out_ready=0.
  - On an edge with out_ready=1 (transfer), the next selection is made from pending with the current grant already cleared:
    - If any bit remains, load the next index, keep out_valid=1 and stay in HOLD (back-to-back, one transfer per cycle).
    - Otherwise out_valid <= 0 and state -> IDLE.
  - out_sel retains its last value after out_valid drops.
- Latency: in_k high at edge N sets pending[k] at N; from IDLE, out_valid=1 and out_sel=k after edge N+1.
- Simultaneous set and clear:
  - If in_k=1 on the same edge that grants and clears pending[k], set wins and pending[k] stays 1 (new event).
  - Capture of other bits proceeds in parallel with any grant.
- Duplicate events: multiple pulses on in_k before issue collapse into one pending bit, giving one grant. No counting; this is intended.
- out_ready while out_valid=0 is ignored.
- Output widths: out_sel exactly 2 bits; pending exactly 4 bits. No X on any output after reset.

Test Plan:
- Reset check: rst_n=0 asserted mid-cycle with pending=4'b1010 and out_valid=1 -> pending=0, out_valid=0 and out_sel=0 immediately, before the next clk edge.
- Single event: one-cycle pulse on in_2 with out_ready=1 -> pending=4'b0100 after 1 edge; out_valid=1 and out_sel=2 after 2 edges; out_valid=0 and pending=0 after 3 edges.
- Round-robin wrap, RR_MODE=1: pulse in_0..in_3 together, out_ready=1 -> out_sel sequence 0,1,2,3 on consecutive cycles. Then pulse in_0 and in_3 -> 0 then 3. Then pulse in_0 and in_3 again -> 0 then 3, since the pointer wrapped to 0 after granting 3.
- Fixed priority, RR_MODE=0: hold in_3 high continuously and pulse in_1 once, out_ready=1 -> grant 1 first, then 3 every cycle thereafter.
- Backpressure: in_1 and in_2 pulsed, out_ready=0 for 5 cycles -> out_valid=1 and out_sel=1 stable throughout; raise out_ready -> 1 accepted, then 2 on the next cycle, then out_valid=0.
- Set-during-clear: in_0 high on the exact edge pending[0] is granted -> pending[0] remains 1 and a second grant of 0 follows after the first transfer.
